uart_rx_nodr_core: RTL and testbench

//  - UART receiver, 8N1, LSB first; deserialises line `in` into a byte on `out`.
//  - Sticky data-ready flag `dr` is cleared by the consumer via `dr_rst`.
//  - "no_dr": reception never waits on `dr`. A completed frame always overwrites `out`.
//  - Sits between the async RX pin (already synchronised upstream) and a polled/IRQ consumer.

---
 rtl/uart_rx_nodr_core_if.sv | 12 +
 rtl/uart_rx_nodr_core.sv | 100 ++++++++++
 tb/tb_uart_rx_nodr_core.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_nodr_core_if.sv
// Bus bundle for uart_rx_nodr_core: serial line in, received byte / data-ready out,
// consumer clear of data-ready, plus the receiver FSM state for observation.
interface uart_rx_nodr_core_if;
  logic       in;
  logic [7:0] out;
  logic       dr;
  logic       dr_rst;
  logic [1:0] state_dbg;

  modport slave  (input in, dr_rst, output out, dr, state_dbg);
  modport master (output in, dr_rst, input out, dr, state_dbg);
endinterface

// File: rtl/uart_rx_nodr_core.sv
// 8N1 UART receiver, LSB first, sticky dr flag that never stalls reception.
// Optional macro UART_RX_STOP_CHECK_EN discards frames whose stop sample is 0.
module uart_rx_nodr_core #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_rx_nodr_core_if.slave bus
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    out_r;
  logic          dr_r;
  logic          tick;
  logic          stop_ok;
  logic          commit;

  always_comb begin
    tick = (clk_cnt == LAST_CNT);
`ifdef UART_RX_STOP_CHECK_EN
    stop_ok = bus.in;
`else
    stop_ok = 1'b1;
`endif
    commit = (state == STOP) && tick && stop_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      out_r   <= '0;
      dr_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          // With one clk per bit the detecting sample is already the start bit.
          if (!bus.in) state <= (CLKS_PER_BIT == 1) ? DATA : START;
        end
        START: begin
          if (clk_cnt == HALF_CNT) begin
            clk_cnt <= '0;
            state   <= bus.in ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            clk_cnt <= '0;
            shift   <= {bus.in, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (commit) out_r <= shift;

      // A commit on the same edge as dr_rst wins so no byte goes unnoticed.
      if (commit)          dr_r <= 1'b1;
      else if (bus.dr_rst) dr_r <= 1'b0;
    end
  end

  assign bus.out       = out_r;
  assign bus.dr        = dr_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_uart_rx_nodr_core.sv
// Randomized and directed bench for uart_rx_nodr_core at one bit per clk.
module tb_uart_rx_nodr_core;

  localparam time T = 200;
`ifdef UART_RX_STOP_CHECK_EN
  localparam bit STOP_CHECK = 1'b1;
`else
  localparam bit STOP_CHECK = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #(T/2) clk = ~clk;

  uart_rx_nodr_core_if bus ();

  uart_rx_nodr_core #(.CLKS_PER_BIT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model: last committed byte and sticky flag
  logic [7:0] m_out;
  logic       m_dr;
  logic [7:0] exp_q[$];

  // drivers
  task automatic step(input logic b, input logic r);
    bus.in     = b;
    bus.dr_rst = r;
    @(posedge clk);
    #1;
  endtask

  // Bit index 0 = start, 1..8 = data LSB first, 9 = stop.
  task automatic send_bits(input logic [7:0] data, input logic stop,
                           input logic [9:0] mask, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      logic b;
      if (i == 0)      b = 1'b0;
      else if (i < 9)  b = data[i-1];
      else             b = stop;
      step(b, mask[i]);
      if (i == 9 && (stop || !STOP_CHECK)) begin
        m_out = data;
        m_dr  = 1'b1;
        exp_q.push_back(data);
      end else if (mask[i]) begin
        m_dr = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic [9:0] mask);
    send_bits(data, stop, mask, 0, 9);
  endtask

  task automatic send_idle(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      step(1'b1, r);
      if (r) m_dr = 1'b0;
    end
  endtask

  // tests
  task automatic test_reset();
    bus.in = 1'b1; bus.dr_rst = 1'b0;
    rst_n = 1'b0;
    #10;
    checks++;
    if (bus.out !== 8'h00) begin errors++; $display("FAIL reset_out got=%h want=00", bus.out); end
    checks++;
    if (bus.dr !== 1'b0) begin errors++; $display("FAIL reset_dr got=%b want=0", bus.dr); end
    repeat (2) @(posedge clk);
    #50 rst_n = 1'b1;
    m_out = 8'h00; m_dr = 1'b0; exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_idle_frame();
    send_idle(8, 1'b0);
    send_frame(8'hBB, 1'b1, 10'h000);
    checks++;
    if (bus.out !== 8'hBB) begin errors++; $display("FAIL idle_frame_out got=%h want=bb", bus.out); end
    checks++;
    if (bus.dr !== 1'b1) begin errors++; $display("FAIL idle_frame_dr got=%b want=1", bus.dr); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_back_to_back();
    send_idle(3, 1'b0);
    send_bits(8'h55, 1'b1, 10'b00_0000_1000, 0, 3);
    checks++;
    if (bus.dr !== 1'b0) begin errors++; $display("FAIL b2b_dr_clear got=%b want=0", bus.dr); end
    checks++;
    if (bus.out !== 8'hBB) begin errors++; $display("FAIL b2b_out_stable got=%h want=bb", bus.out); end
    send_bits(8'h55, 1'b1, 10'b00_0000_1000, 4, 9);
    checks++;
    if (bus.out !== 8'h55) begin errors++; $display("FAIL b2b_out got=%h want=55", bus.out); end
    checks++;
    if (bus.dr !== 1'b1) begin errors++; $display("FAIL b2b_dr got=%b want=1", bus.dr); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_collision();
    send_idle(1, 1'b1);
    send_frame(8'h55, 1'b1, 10'b10_0000_0000);
    checks++;
    if (bus.dr !== 1'b1) begin errors++; $display("FAIL collision_set_wins got=%b want=1", bus.dr); end
    send_idle(1, 1'b1);
    checks++;
    if (bus.dr !== 1'b0) begin errors++; $display("FAIL collision_clear_after got=%b want=0", bus.dr); end
    checks++;
    if (bus.out !== 8'h55) begin errors++; $display("FAIL collision_out got=%h want=55", bus.out); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_overwrite();
    send_idle(2, 1'b0);
    send_frame(8'h3C, 1'b1, 10'h000);
    checks++;
    if (bus.out !== 8'h3C) begin errors++; $display("FAIL overwrite_first got=%h want=3c", bus.out); end
    send_bits(8'hA5, 1'b1, 10'h000, 0, 5);
    checks++;
    if (bus.out !== 8'h3C || bus.dr !== 1'b1) begin
      errors++; $display("FAIL overwrite_mid got=%h/%b want=3c/1", bus.out, bus.dr);
    end
    send_bits(8'hA5, 1'b1, 10'h000, 6, 9);
    checks++;
    if (bus.out !== 8'hA5 || bus.dr !== 1'b1) begin
      errors++; $display("FAIL overwrite_second got=%h/%b want=a5/1", bus.out, bus.dr);
    end
    exp_q.delete();
  endtask

  task automatic test_bad_stop();
    logic [7:0] want_out;
    send_idle(1, 1'b1);
    send_frame(8'h81, 1'b0, 10'h000);
    want_out = STOP_CHECK ? 8'hA5 : 8'h81;
    checks++;
    if (bus.out !== want_out) begin errors++; $display("FAIL bad_stop_out got=%h want=%h", bus.out, want_out); end
    checks++;
    if (bus.dr !== m_dr) begin errors++; $display("FAIL bad_stop_dr got=%b want=%b", bus.dr, m_dr); end
    exp_q.delete();
  endtask

  task automatic test_break();
    send_idle(1, 1'b1);
    send_frame(8'h00, 1'b0, 10'h000);
    send_frame(8'h00, 1'b0, 10'h000);
    send_idle(2, 1'b0);
    checks++;
    if (bus.out !== m_out) begin errors++; $display("FAIL break_out got=%h want=%h", bus.out, m_out); end
    checks++;
    if (bus.dr !== m_dr) begin errors++; $display("FAIL break_dr got=%b want=%b", bus.dr, m_dr); end
    send_frame(8'hC3, 1'b1, 10'h000);
    checks++;
    if (bus.out !== 8'hC3) begin errors++; $display("FAIL break_recover got=%h want=c3", bus.out); end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    send_idle(1, 1'b0);
    send_bits(8'h5A, 1'b1, 10'h000, 0, 4);
    #50 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out !== 8'h00 || bus.dr !== 1'b0) begin
      errors++; $display("FAIL mid_reset got=%h/%b want=00/0", bus.out, bus.dr);
    end
    m_out = 8'h00; m_dr = 1'b0; exp_q.delete();
    bus.in = 1'b1;
    @(posedge clk);
    #50 rst_n = 1'b1;
    @(posedge clk); #1;
    send_idle(2, 1'b0);
    send_frame(8'h42, 1'b1, 10'h000);
    checks++;
    if (bus.out !== 8'h42 || bus.dr !== 1'b1) begin
      errors++; $display("FAIL mid_reset_next got=%h/%b want=42/1", bus.out, bus.dr);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      logic [7:0] data;
      logic       stop;
      logic [9:0] mask;
      int         gap;
      data = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      gap  = $urandom_range(0, 3);
      mask = '0;
      for (int i = 0; i < 10; i++) mask[i] = ($urandom_range(0, 5) == 0);
      send_idle(gap, 1'($urandom_range(0, 3) == 0));
      send_frame(data, stop, mask);
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++;
        if (bus.out !== e) begin errors++; $display("FAIL random_out frame=%0d got=%h want=%h", f, bus.out, e); end
      end else begin
        checks++;
        if (bus.out !== m_out) begin errors++; $display("FAIL random_hold frame=%0d got=%h want=%h", f, bus.out, m_out); end
      end
      checks++;
      if (bus.dr !== m_dr) begin errors++; $display("FAIL random_dr frame=%0d got=%b want=%b", f, bus.dr, m_dr); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_frame();
    test_back_to_back();
    test_collision();
    test_overwrite();
    test_bad_stop();
    test_break();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
